spi_master_tx: RTL and testbench

Byte-oriented SPI master (mode 0, MSB first, 8-bit words). It is the initiator counterpart of the FPGA-side SPI slave that receives game and pixel bytes. It drains a small transmit FIFO onto MOSI and holds chip-select low across back-to-back bytes, forming one frame. It returns each byte captured on MISO with a one-cycle valid strobe. It drives a second SPI peripheral from the pacman fabric and serves as the Pi stand-in in slave test benches.

---
 rtl/spi_master_tx_if.sv | 25 ++
 rtl/spi_master_tx.sv | 137 +++++++++++++
 tb/tb_spi_master_tx.sv | 289 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/spi_master_tx_if.sv
// Host byte stream plus SPI pins of spi_master_tx. The master modport is the
// SPI master's own view; the slave modport is the host/peripheral side.
interface spi_master_tx_if;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       sck;
  logic       mosi;
  logic       miso;
  logic       cs_n;
  logic       busy;
  logic       frame_done;

  modport master (
    input  tx_data, tx_valid, miso,
    output tx_ready, rx_data, rx_valid, sck, mosi, cs_n, busy, frame_done
  );

  modport slave (
    output tx_data, tx_valid, miso,
    input  tx_ready, rx_data, rx_valid, sck, mosi, cs_n, busy, frame_done
  );
endinterface

// File: rtl/spi_master_tx.sv
// Mode-0 byte SPI master: drains a small TX FIFO MSB-first onto mosi, keeps
// cs_n low across back-to-back bytes and returns each MISO byte with a strobe.
module spi_master_tx #(
  parameter int CLK_DIV    = 4,
  parameter int FIFO_DEPTH = 4
) (
  input  logic            clk,
  input  logic            reset,
  spi_master_tx_if.master bus
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam int DW = $clog2(CLK_DIV);
  localparam logic [CW-1:0] FULL     = CW'(FIFO_DEPTH);
  localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);

  typedef enum logic [1:0] {IDLE, SETUP, HIGH, TAIL} state_t;

  state_t        state;
  logic [DW-1:0] div_cnt;
  logic [2:0]    bit_cnt;
  logic [7:0]    tx_sh;
  logic [7:0]    rx_sh;
  logic [7:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic [7:0]    head;
  logic          push;
  logic          pop;
  logic          empty;
  logic          tick;
  logic          last_bit;

  assign empty        = (count == '0);
  assign head         = mem[rd_ptr];
  assign bus.tx_ready = (count != FULL);
  assign push         = bus.tx_valid && bus.tx_ready;
  assign tick         = (div_cnt == DIV_LAST);
  assign last_bit     = (bit_cnt == 3'd7);
  // The next byte is fetched either from idle or right at the end of bit 7,
  // so a queued byte continues the frame without releasing cs_n.
  assign pop          = !empty && ((state == IDLE) || (state == HIGH && tick && last_bit));
  assign bus.busy     = (state != IDLE);

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= bus.tx_data;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: ;
      endcase
    end
  end

  // Shift registers hold data only; control state decides when they move.
  always_ff @(posedge clk) begin
    if (pop)                        tx_sh <= head;
    else if (state == HIGH && tick) tx_sh <= {tx_sh[6:0], 1'b0};
    if (state == SETUP && tick)     rx_sh <= {rx_sh[6:0], bus.miso};
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state          <= IDLE;
      div_cnt        <= '0;
      bit_cnt        <= '0;
      bus.sck        <= 1'b0;
      bus.mosi       <= 1'b0;
      bus.cs_n       <= 1'b1;
      bus.rx_data    <= 8'h00;
      bus.rx_valid   <= 1'b0;
      bus.frame_done <= 1'b0;
    end else begin
      bus.rx_valid   <= 1'b0;
      bus.frame_done <= 1'b0;
      // Every state change other than leaving IDLE happens on a tick, so
      // clearing on tick or in IDLE restarts the divider on each entry.
      div_cnt <= (tick || state == IDLE) ? '0 : div_cnt + DW'(1);
      case (state)
        IDLE: begin
          if (!empty) begin
            bus.mosi <= head[7];
            bit_cnt  <= '0;
            bus.cs_n <= 1'b0;
            state    <= SETUP;
          end
        end
        SETUP: begin
          if (tick) begin
            bus.sck <= 1'b1;
            state   <= HIGH;
          end
        end
        HIGH: begin
          if (tick) begin
            bus.sck <= 1'b0;
            if (!last_bit) begin
              bus.mosi <= tx_sh[6];
              bit_cnt  <= bit_cnt + 3'd1;
              state    <= SETUP;
            end else begin
              bus.rx_data  <= rx_sh;
              bus.rx_valid <= 1'b1;
              if (!empty) begin
                bus.mosi <= head[7];
                bit_cnt  <= '0;
                state    <= SETUP;
              end else begin
                state <= TAIL;
              end
            end
          end
        end
        TAIL: begin
          if (tick) begin
            bus.cs_n       <= 1'b1;
            bus.frame_done <= 1'b1;
            bus.mosi       <= 1'b0;
            state          <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_spi_master_tx.sv
// Directed bench for spi_master_tx: CLK_DIV=2 and CLK_DIV=4 instances, table
// of frame transactions plus hand-written stall, reset and TAIL sequences.
module tb_spi_master_tx;
  logic clk   = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  spi_master_tx_if if2();
  spi_master_tx_if if4();

  spi_master_tx #(.CLK_DIV(2), .FIFO_DEPTH(4)) dut2 (.clk(clk), .reset(reset), .bus(if2));
  spi_master_tx #(.CLK_DIV(4), .FIFO_DEPTH(4)) dut4 (.clk(clk), .reset(reset), .bus(if4));

  // MISO source for dut2: loopback, or a mode-0 slave returning sl_byte
  logic       loop2;
  logic [7:0] sl_byte;
  logic [2:0] sl_idx;
  logic       sl_sck_q;
  assign if2.miso = loop2 ? if2.mosi : sl_byte[3'd7 - sl_idx];
  assign if4.miso = if4.mosi;

  always @(posedge clk) begin
    sl_sck_q <= if2.sck;
    if (if2.cs_n) sl_idx <= 3'd0;
    else if (sl_sck_q && !if2.sck) sl_idx <= sl_idx + 3'd1;
  end

  int         cyc, run2, hi2, fd2, viol2;
  int         csl2[$], hiq2[$], rxt2[$];
  logic [7:0] rxq2[$];
  logic       mosiq2[$];
  logic       sck_q2, mosi_q2;

  always @(negedge clk) begin
    cyc     <= cyc + 1;
    sck_q2  <= if2.sck;
    mosi_q2 <= if2.mosi;
    if (reset) begin
      run2 <= 0;
      hi2  <= 0;
    end else begin
      if (!if2.cs_n) begin
        run2 <= run2 + 1;
        hi2  <= 0;
        if (run2 == 0) hiq2.push_back(hi2);
      end else begin
        hi2 <= hi2 + 1;
        if (run2 != 0) begin
          csl2.push_back(run2);
          run2 <= 0;
        end
      end
      if (if2.rx_valid) begin
        rxq2.push_back(if2.rx_data);
        rxt2.push_back(cyc);
      end
      if (if2.frame_done) fd2 <= fd2 + 1;
      if (if2.sck && !sck_q2) mosiq2.push_back(if2.mosi);
      viol2 <= viol2 + int'(if2.sck && (if2.mosi != mosi_q2))
                     + int'((if2.sck != sck_q2) && if2.cs_n)
                     + int'(if2.cs_n && (run2 != 0) && !if2.frame_done)
                     + int'(if2.frame_done && (run2 == 0));
    end
  end

  int         run4, hi4, fd4, viol4;
  int         csl4[$], hiq4[$];
  logic [7:0] rxq4[$];
  logic       sck_q4, mosi_q4;

  always @(negedge clk) begin
    sck_q4  <= if4.sck;
    mosi_q4 <= if4.mosi;
    if (reset) begin
      run4 <= 0;
      hi4  <= 0;
    end else begin
      if (!if4.cs_n) begin
        run4 <= run4 + 1;
        hi4  <= 0;
        if (run4 == 0) hiq4.push_back(hi4);
      end else begin
        hi4 <= hi4 + 1;
        if (run4 != 0) begin
          csl4.push_back(run4);
          run4 <= 0;
        end
      end
      if (if4.rx_valid) rxq4.push_back(if4.rx_data);
      if (if4.frame_done) fd4 <= fd4 + 1;
      viol4 <= viol4 + int'(if4.sck && (if4.mosi != mosi_q4))
                     + int'((if4.sck != sck_q4) && if4.cs_n)
                     + int'(if4.cs_n && (run4 != 0) && !if4.frame_done)
                     + int'(if4.frame_done && (run4 == 0));
    end
  end

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  task automatic wait_frames2(input int target);
    for (int k = 0; k < 4000; k++) begin
      if (csl2.size() >= target) break;
      @(posedge clk);
    end
  endtask

  task automatic wait_frames4(input int target);
    for (int k = 0; k < 4000; k++) begin
      if (csl4.size() >= target) break;
      @(posedge clk);
    end
  endtask

  function automatic logic [7:0] mosi_byte2(input int base);
    logic [7:0] b;
    b = '0;
    for (int k = 0; k < 8; k++)
      b = {b[6:0], (base + k < mosiq2.size()) ? mosiq2[base + k] : 1'b0};
    return b;
  endfunction

  typedef struct packed {
    int              n;
    logic [5:0][7:0] tx;
    logic            loop;
    logic [7:0]      slave;
    logic [5:0][7:0] exp_rx;
    int              exp_cs;
    int              exp_gap;
  } vec_t;

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    vec_t vt [4];
    int   s_rx, s_fr, s_fd, s_mo, s_h, idx, stall_at, stalled, act;
    logic acc, in_tail;

    vt[0] = '{n: 1, tx: 48'h0000_0000_00A5, loop: 1'b0, slave: 8'h3C,
              exp_rx: 48'h0000_0000_003C, exp_cs: 34, exp_gap: 32};
    vt[1] = '{n: 3, tx: 48'h0000_005A_FF00, loop: 1'b1, slave: 8'h00,
              exp_rx: 48'h0000_005A_FF00, exp_cs: 98, exp_gap: 32};
    vt[2] = '{n: 1, tx: 48'h0000_0000_0080, loop: 1'b0, slave: 8'h01,
              exp_rx: 48'h0000_0000_0001, exp_cs: 34, exp_gap: 32};
    vt[3] = '{n: 2, tx: 48'h0000_0000_C33C, loop: 1'b1, slave: 8'h00,
              exp_rx: 48'h0000_0000_C33C, exp_cs: 66, exp_gap: 32};

    if2.tx_valid = 1'b0; if2.tx_data = 8'h00;
    if4.tx_valid = 1'b0; if4.tx_data = 8'h00;
    loop2 = 1'b1; sl_byte = 8'h00;
    #1 reset = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_sck", if2.sck, 1'b0);
    check("rst_mosi", if2.mosi, 1'b0);
    check("rst_cs_n", if2.cs_n, 1'b1);
    check("rst_rx_data", if2.rx_data, 8'h00);
    check("rst_rx_valid", if2.rx_valid, 1'b0);
    check("rst_frame_done", if2.frame_done, 1'b0);
    check("rst_busy", if2.busy, 1'b0);
    check("rst_tx_ready", if2.tx_ready, 1'b1);
    #2 reset = 1'b0;
    repeat (3) @(negedge clk);

    for (int t = 0; t < 4; t++) begin
      loop2 = vt[t].loop; sl_byte = vt[t].slave;
      s_rx = rxq2.size(); s_fr = csl2.size(); s_fd = fd2; s_mo = mosiq2.size();
      for (int i = 0; i < vt[t].n; i++) begin
        @(negedge clk);
        if2.tx_data = vt[t].tx[i]; if2.tx_valid = 1'b1;
      end
      @(negedge clk); if2.tx_valid = 1'b0;
      wait_frames2(s_fr + 1);
      repeat (4) @(negedge clk);
      check($sformatf("v%0d_frames", t), csl2.size() - s_fr, 1);
      act = (csl2.size() > s_fr) ? csl2[s_fr] : -1;
      check($sformatf("v%0d_cs_low", t), act, vt[t].exp_cs);
      check($sformatf("v%0d_frame_done", t), fd2 - s_fd, 1);
      check($sformatf("v%0d_rx_count", t), rxq2.size() - s_rx, vt[t].n);
      for (int i = 0; i < vt[t].n; i++) begin
        check($sformatf("v%0d_rx%0d", t, i), rxq2[s_rx + i], vt[t].exp_rx[i]);
        check($sformatf("v%0d_mosi%0d", t, i), mosi_byte2(s_mo + 8 * i), vt[t].tx[i]);
      end
      for (int i = 0; i + 1 < vt[t].n; i++)
        check($sformatf("v%0d_gap%0d", t, i), rxt2[s_rx + i + 1] - rxt2[s_rx + i], vt[t].exp_gap);
    end

    // FIFO fill and stall: 0x01..0x06 with tx_valid held high, loopback
    loop2 = 1'b1;
    s_rx = rxq2.size(); s_fr = csl2.size();
    idx = 0; acc = 1'b0; stall_at = -1; stalled = 0;
    for (int g = 0; g < 3000 && idx < 6; g++) begin
      @(negedge clk);
      if (acc) idx++;
      if (idx < 6) begin
        if2.tx_data = 8'(idx + 1); if2.tx_valid = 1'b1;
        acc = if2.tx_ready;
        if (!acc) begin
          stalled++;
          if (stall_at < 0) stall_at = idx;
        end
      end
    end
    if2.tx_valid = 1'b0;
    check("stall_first_blocked_idx", stall_at, 5);
    check("stall_cycles", stalled, 29);
    check("stall_all_accepted", idx, 6);
    wait_frames2(s_fr + 1);
    repeat (4) @(negedge clk);
    check("fill_frames", csl2.size() - s_fr, 1);
    act = (csl2.size() > s_fr) ? csl2[s_fr] : -1;
    check("fill_cs_low", act, 194);
    check("fill_rx_count", rxq2.size() - s_rx, 6);
    for (int i = 0; i < 6; i++)
      check($sformatf("fill_rx%0d", i), rxq2[s_rx + i], 8'(i + 1));

    // Reset during bit 3 of 0xC3 with two more bytes queued
    s_rx = rxq2.size(); s_fr = csl2.size(); s_mo = mosiq2.size();
    @(negedge clk); if2.tx_data = 8'hC3; if2.tx_valid = 1'b1;
    @(negedge clk); if2.tx_data = 8'h11;
    @(negedge clk); if2.tx_data = 8'h22;
    @(negedge clk); if2.tx_valid = 1'b0;
    for (int g = 0; g < 500; g++) begin
      if (mosiq2.size() >= s_mo + 4) break;
      @(negedge clk);
    end
    check("mid_reset_reached_bit3", mosiq2.size() - s_mo, 4);
    #2 reset = 1'b1;
    #1;
    check("mid_reset_sck", if2.sck, 1'b0);
    check("mid_reset_cs_n", if2.cs_n, 1'b1);
    check("mid_reset_busy", if2.busy, 1'b0);
    check("mid_reset_tx_ready", if2.tx_ready, 1'b1);
    check("mid_reset_rx_valid", if2.rx_valid, 1'b0);
    check("mid_reset_mosi", if2.mosi, 1'b0);
    @(negedge clk); #2 reset = 1'b0;
    act = 0;
    repeat (60) begin
      @(negedge clk);
      if (!if2.cs_n || if2.busy || if2.sck || if2.rx_valid) act++;
    end
    check("post_reset_activity", act, 0);
    check("post_reset_rx", rxq2.size() - s_rx, 0);
    check("post_reset_frames", csl2.size() - s_fr, 0);
    check("post_reset_tx_ready", if2.tx_ready, 1'b1);

    // CLK_DIV=4: 0x81, then 0x7E pushed during TAIL of the first frame
    s_fr = csl4.size(); s_fd = fd4; s_rx = rxq4.size(); s_h = hiq4.size();
    @(negedge clk); if4.tx_data = 8'h81; if4.tx_valid = 1'b1;
    @(negedge clk); if4.tx_valid = 1'b0;
    for (int g = 0; g < 2000; g++) begin
      @(negedge clk);
      if (if4.rx_valid) break;
    end
    if4.tx_data = 8'h7E; if4.tx_valid = 1'b1;
    in_tail = if4.busy && !if4.cs_n && if4.rx_valid;
    @(negedge clk); if4.tx_valid = 1'b0;
    check("tail_push_in_tail", in_tail, 1'b1);
    wait_frames4(s_fr + 2);
    repeat (4) @(negedge clk);
    check("tail_frames", csl4.size() - s_fr, 2);
    act = (csl4.size() > s_fr) ? csl4[s_fr] : -1;
    check("tail_cs_low0", act, 68);
    act = (csl4.size() > s_fr + 1) ? csl4[s_fr + 1] : -1;
    check("tail_cs_low1", act, 68);
    check("tail_frame_done", fd4 - s_fd, 2);
    act = (hiq4.size() > s_h + 1) ? hiq4[s_h + 1] : 0;
    check("tail_cs_gap_ge1", act >= 1, 1'b1);
    check("tail_rx_count", rxq4.size() - s_rx, 2);
    check("tail_rx0", rxq4[s_rx], 8'h81);
    check("tail_rx1", rxq4[s_rx + 1], 8'h7E);

    check("invariants_div2", viol2, 0);
    check("invariants_div4", viol4, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
